// File: rtl/cvxif_result_buffer.sv
// In-order result queue between the coprocessor execution unit and the CV-X-IF result channel.
// Entries killed by the commit interface are retired silently and counted in drop_cnt_o.
module cvxif_result_buffer #(
  parameter int unsigned Depth   = 4,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned IdWidth = 3,
  parameter int unsigned RdWidth = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IdWidth-1:0]         in_id_i,
  input  logic [XLEN-1:0]            in_data_i,
  input  logic [RdWidth-1:0]         in_rd_i,
  input  logic                       in_we_i,
  input  logic                       in_exc_i,
  input  logic [5:0]                 in_exccode_i,
  input  logic                       commit_valid_i,
  input  logic [IdWidth-1:0]         commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [IdWidth-1:0]         result_id_o,
  output logic [XLEN-1:0]            result_data_o,
  output logic [RdWidth-1:0]         result_rd_o,
  output logic                       result_we_o,
  output logic                       result_exc_o,
  output logic [5:0]                 result_exccode_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [IdWidth-1:0] id_q      [Depth];
  logic [XLEN-1:0]    data_q    [Depth];
  logic [RdWidth-1:0] rd_q      [Depth];
  logic [5:0]         exccode_q [Depth];
  logic [Depth-1:0]   we_q, exc_q, killed_q;

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic [15:0]     drop_q;

  logic head_occ, head_killed, push, pop, kill;

  always_comb begin
    head_occ    = (count_q != '0);
    head_killed = killed_q[rptr_q];
    in_ready_o  = (count_q != CntW'(Depth));
    push        = in_valid_i && in_ready_o && !flush_i;
    // A killed head retires without a handshake.
    pop         = head_occ && (head_killed || result_ready_i) && !flush_i;
    kill        = commit_valid_i && commit_kill_i && !flush_i;

    result_valid_o   = head_occ && !head_killed;
    result_id_o      = id_q[rptr_q];
    result_data_o    = data_q[rptr_q];
    result_rd_o      = rd_q[rptr_q];
    result_we_o      = we_q[rptr_q];
    result_exc_o     = exc_q[rptr_q];
    result_exccode_o = exccode_q[rptr_q];
    count_o          = count_q;
    drop_cnt_o       = drop_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        id_q[i]      <= '0;
        data_q[i]    <= '0;
        rd_q[i]      <= '0;
        exccode_q[i] <= '0;
      end
      we_q  <= '0;
      exc_q <= '0;
    end else if (push) begin
      id_q[wptr_q]      <= in_id_i;
      data_q[wptr_q]    <= in_data_i;
      rd_q[wptr_q]      <= in_rd_i;
      exccode_q[wptr_q] <= in_exccode_i;
      we_q[wptr_q]      <= in_we_i;
      exc_q[wptr_q]     <= in_exc_i;
    end
  end

  // Killed bits of free slots are don't-care: every push rewrites its slot's bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      killed_q <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (push && (wptr_q == PtrW'(i))) begin
          killed_q[i] <= kill && (in_id_i == commit_id_i);
        end else if (kill && (id_q[i] == commit_id_i)) begin
          killed_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + PtrW'(push);
      rptr_q  <= rptr_q + PtrW'(pop);
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (head_occ && head_killed && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Directed bench for cvxif_result_buffer: ordering, back-pressure, kill, flush and reset.
module tb_cvxif_result_buffer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_id = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic        in_exc = 1'b0;
  logic [5:0]  in_exccode = '0;
  logic        commit_valid = 1'b0;
  logic [2:0]  commit_id = '0;
  logic        commit_kill = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [2:0]  result_id;
  logic [63:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;
  logic        result_exc;
  logic [5:0]  result_exccode;
  logic [2:0]  count;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  cvxif_result_buffer #(.Depth(4), .XLEN(64), .IdWidth(3), .RdWidth(5)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_id_i          (in_id),
    .in_data_i        (in_data),
    .in_rd_i          (in_rd),
    .in_we_i          (in_we),
    .in_exc_i         (in_exc),
    .in_exccode_i     (in_exccode),
    .commit_valid_i   (commit_valid),
    .commit_id_i      (commit_id),
    .commit_kill_i    (commit_kill),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready),
    .result_id_o      (result_id),
    .result_data_o    (result_data),
    .result_rd_o      (result_rd),
    .result_we_o      (result_we),
    .result_exc_o     (result_exc),
    .result_exccode_o (result_exccode),
    .count_o          (count),
    .drop_cnt_o       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [2:0] id, input logic [63:0] data);
    in_valid = 1'b1;
    in_id    = id;
    in_data  = data;
    in_rd    = 5'(id) + 5'd1;
    in_we    = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++;
    if (result_data !== 64'd0 || result_id !== 3'd0 || result_rd !== 5'd0)
      begin errors++; $display("FAIL reset_payload: got id %0d data %0h rd %0d want 0 0 0",
                               result_id, result_data, result_rd); end
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_id    = 3'(i);
      in_data  = 64'(100 + i);
      in_rd    = 5'(i + 1);
      checks++;
      if (i == 0 && result_valid !== 1'b0)
        begin errors++; $display("FAIL order_bypass: got valid %b want 0", result_valid); end
      tick();
      checks++;
      if (result_valid !== 1'b1 || result_id !== 3'(i) || result_data !== 64'(100 + i) ||
          result_rd !== 5'(i + 1))
        begin errors++; $display("FAIL order_head%0d: got v%b id %0d data %0d rd %0d want v1 id %0d data %0d rd %0d",
                                 i, result_valid, result_id, result_data, result_rd, i, 100 + i, i + 1); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (count !== 3'd0 || result_valid !== 1'b0)
      begin errors++; $display("FAIL order_drain: got count %0d valid %b want 0 0", count, result_valid); end
    result_ready = 1'b0;
  endtask

  task automatic test_full();
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(3'(i), 64'(200 + i));
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0)
      begin errors++; $display("FAIL full_state: got count %0d in_ready %b want 4 0", count, in_ready); end
    push_one(3'd7, 64'd999);
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL full_reject: got count %0d want 4", count); end
    result_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (result_valid !== 1'b1 || result_id !== 3'(i) || result_data !== 64'(200 + i))
        begin errors++; $display("FAIL full_pop%0d: got v%b id %0d data %0d want v1 id %0d data %0d",
                                 i, result_valid, result_id, result_data, i, 200 + i); end
      tick();
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", in_ready); end
      end
    end
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL full_drain: got count %0d want 0", count); end
    result_ready = 1'b0;
  endtask

  task automatic test_kill_middle();
    logic [15:0] d0;
    d0 = drop_cnt;
    for (int i = 1; i <= 3; i++) push_one(3'(i), 64'(300 + i));
    commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 3'd2;
    tick();
    commit_valid = 1'b0; commit_kill = 1'b0;
    checks++;
    if (count !== 3'd3 || result_id !== 3'd1 || result_valid !== 1'b1)
      begin errors++; $display("FAIL killmid_hold: got count %0d id %0d v%b want 3 1 1", count, result_id, result_valid); end
    result_ready = 1'b1;
    tick();
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL killmid_hidden: got valid %b want 0", result_valid); end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_id !== 3'd3)
      begin errors++; $display("FAIL killmid_next: got v%b id %0d want v1 id 3", result_valid, result_id); end
    tick();
    checks++;
    if (count !== 3'd0 || drop_cnt !== d0 + 16'd1)
      begin errors++; $display("FAIL killmid_drop: got count %0d drop %0d want 0 %0d", count, drop_cnt, d0 + 1); end
    result_ready = 1'b0;
  endtask

  task automatic test_kill_head();
    logic [15:0] d0;
    d0 = drop_cnt;
    push_one(3'd5, 64'd500);
    push_one(3'd6, 64'd600);
    checks++;
    if (result_valid !== 1'b1 || result_id !== 3'd5)
      begin errors++; $display("FAIL killhead_pre: got v%b id %0d want v1 id 5", result_valid, result_id); end
    commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 3'd5;
    tick();
    commit_valid = 1'b0; commit_kill = 1'b0;
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL killhead_fall: got valid %b want 0", result_valid); end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result_id !== 3'd6 || result_data !== 64'd600 || drop_cnt !== d0 + 16'd1)
      begin errors++; $display("FAIL killhead_next: got v%b id %0d data %0d drop %0d want v1 id 6 data 600 drop %0d",
                               result_valid, result_id, result_data, drop_cnt, d0 + 1); end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_push_and_kill();
    logic [15:0] d0;
    d0 = drop_cnt;
    commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 3'd4;
    push_one(3'd4, 64'd400);
    commit_valid = 1'b0; commit_kill = 1'b0;
    checks++;
    if (count !== 3'd1 || result_valid !== 1'b0)
      begin errors++; $display("FAIL pushkill_hidden: got count %0d v%b want 1 0", count, result_valid); end
    tick();
    checks++;
    if (count !== 3'd0 || drop_cnt !== d0 + 16'd1)
      begin errors++; $display("FAIL pushkill_drop: got count %0d drop %0d want 0 %0d", count, drop_cnt, d0 + 1); end
    // A non-kill commit must leave the entry deliverable.
    commit_valid = 1'b1; commit_kill = 1'b0; commit_id = 3'd2;
    push_one(3'd2, 64'd222);
    commit_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result_id !== 3'd2)
      begin errors++; $display("FAIL commit_nokill: got v%b id %0d want v1 id 2", result_valid, result_id); end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_flush_and_reset();
    logic [15:0] d0;
    d0 = drop_cnt;
    for (int i = 0; i < 3; i++) push_one(3'(i), 64'(700 + i));
    flush = 1'b1;
    push_one(3'd3, 64'd703);
    flush = 1'b0;
    checks++;
    if (count !== 3'd0 || in_ready !== 1'b1 || result_valid !== 1'b0 || drop_cnt !== d0)
      begin errors++; $display("FAIL flush_state: got count %0d rdy %b v%b drop %0d want 0 1 0 %0d",
                               count, in_ready, result_valid, drop_cnt, d0); end
    push_one(3'd6, 64'd706);
    checks++;
    if (count !== 3'd1 || result_id !== 3'd6 || result_data !== 64'd706)
      begin errors++; $display("FAIL flush_restart: got count %0d id %0d data %0d want 1 6 706",
                               count, result_id, result_data); end
    push_one(3'd7, 64'd707);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || result_valid !== 1'b0 || in_ready !== 1'b1 || drop_cnt !== 16'd0 ||
        result_data !== 64'd0 || result_id !== 3'd0)
      begin errors++; $display("FAIL async_reset: got count %0d v%b rdy %b drop %0d data %0d id %0d want 0 0 1 0 0 0",
                               count, result_valid, in_ready, drop_cnt, result_data, result_id); end
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_kill_middle();
    test_kill_head();
    test_push_and_kill();
    test_flush_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
